iob_fir_decim: RTL and testbench
================================

# iob_fir_decim

Downstream consumer of the FIR filter: takes one unsigned FIR output sample per enabled clock, integrates DECIM consecutive samples (integrate-and-dump), rounds and saturates the sum to OUT_W bits, and queues the results in a small FIFO. The FIFO is drained through a valid/ready port. This block rate-reduces and narrows the filter stream before it reaches the system bus or peripheral logic.

## Interface
- DATA_W, 13: width of the unsigned FIR sample input.
- OUT_W, 8: width of a decimated output word; 1 ≤ OUT_W ≤ ACC_W.
- DECIM_LOG2, 2: log2 of the decimation factor; DECIM = 2^DECIM_LOG2 (4 by default).
- FIFO_AW, 2: FIFO address width; depth = 2^FIFO_AW (4 by default).
- Derived constants: ACC_W = DATA_W + DECIM_LOG2 (15); SHIFT = ACC_W − OUT_W (7).

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- clr  in  1  synchronous clear of accumulator, counter, FIFO and overflow; takes priority over all other inputs.
- en  in  1  sample strobe; data_in is accepted on a rising edge when en = 1.
- data_in  in  DATA_W  unsigned FIR output sample.
- out_data  out  OUT_W  head-of-FIFO word; valid only while out_valid = 1.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data on a rising edge when out_valid = 1 and out_ready = 1.
- level  out  FIFO_AW+1  number of words currently in the FIFO (0..2^FIFO_AW).
- overflow  out  1  sticky flag: a result was dropped because the FIFO was full.

## Operation
- The datapath consists of an accumulator acc[ACC_W], a sample counter cnt[DECIM_LOG2], and a FIFO with read pointer, write pointer and count.
- Each accepted sample (en = 1, clr = 0):
  - If cnt < DECIM−1: acc ← acc + data_in, then cnt ← cnt + 1.
  - If cnt = DECIM−1: sum = acc + data_in. The result is computed, acc ← 0 and cnt ← 0, and a push is requested.
- Result computation:
  - r = (sum + 2^(SHIFT−1)) >> SHIFT, evaluated at ACC_W+1 bits.
  - If r > 2^OUT_W − 1, the result saturates to all ones; otherwise it is r[OUT_W−1:0].
  - When SHIFT = 0 there is no rounding term: the result is sum, saturated.
- Pop: occurs when out_valid = 1 and out_ready = 1.
- Push while the FIFO is full:
  - If a pop occurs in the same cycle, both are performed and level is unchanged.
  - Otherwise the result is discarded, overflow ← 1, and the FIFO is unchanged.
- Push and pop in the same cycle with level < depth: both are performed and level is unchanged.
- Pop with an empty FIFO: impossible, since out_valid = 0.
- en = 0 holds acc and cnt.
- clr = 1: acc, cnt, FIFO pointers and count, and overflow are all zeroed. Any en or handshake in that cycle is ignored.
- overflow is cleared only by clr or by rst.

## Timing
- Reset (rst = 0, asynchronous) sets:
  - out_valid = 0, level = 0, overflow = 0;
  - out_data = 0 (the FIFO storage need not be reset; out_data is forced to 0 while empty);
  - acc = 0 and cnt = 0.
- Deassertion of rst is synchronised externally. The first sample can be accepted on the first rising edge with rst = 1.
- Reset during an integration discards the partial sum and all queued words.
- Latency from the DECIM-th accepted sample edge to the output:
  - Into an empty FIFO: out_valid = 1 and out_data is correct immediately after that edge (1-cycle latency, first-word fall-through from registered storage).
  - level updates on the same edge.
- out_data and out_valid are registered or derived from registers only, with no combinational path from data_in or en.
- out_valid has no combinational dependency on out_ready.
- Sustained throughput is one result per DECIM enabled cycles. With out_ready held at 1, the FIFO never exceeds level 1.
- Counter wrap: cnt returns to 0 on the edge that produces a result, and the next sample starts a new window with acc = 0, so there is no gap cycle.

## Test plan
- Reset and idle:
  - Stimulus: rst = 0, then rst = 1 with en = 0 for 10 cycles.
  - Required response: out_valid = 0, level = 0, overflow = 0, out_data = 0 throughout.
- Rounding with default parameters:
  - Stimulus: four samples of 100 with en = 1 and out_ready = 1.
  - Required response: a single word 3 ((400+64)>>7) appears one cycle after the 4th sample.
  - Stimulus: four samples of 64.
  - Required response: word 2.
- Saturation:
  - Stimulus: four samples of 8191.
  - Required response: word 255, since (32764+64)>>7 = 256 saturates.
- Backpressure and overflow:
  - Stimulus: out_ready = 0 and 20 samples of 100.
  - Required response: level reaches 4 after the 16th sample. The 20th sample sets overflow = 1 and level stays 4.
  - Stimulus: then out_ready = 1.
  - Required response: exactly four words of 3 drain; overflow stays 1.
- Simultaneous push and pop while full:
  - Stimulus: FIFO holds 4 words; raise out_ready on the cycle the next result completes.
  - Required response: level stays 4, overflow stays 0, and word order is preserved.
- Mid-window clear and gated enable:
  - Stimulus: 2 samples of 500, then clr for 1 cycle, then 4 samples of 200 with en toggling 1,0,1,0,... between them.
  - Required response: one word 6 ((800+64)>>7); the pre-clear partial sum is not included.

Source files
------------

// File: rtl/iob_fir_decim.sv
// Integrate-and-dump decimator: sums DECIM unsigned samples, rounds and saturates the
// sum to OUT_W bits, and queues results in a small first-word-fall-through FIFO.
module iob_fir_decim #(
   parameter int DATA_W     = 13,
   parameter int OUT_W      = 8,
   parameter int DECIM_LOG2 = 2,
   parameter int FIFO_AW    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [DATA_W-1:0]  data_in,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FIFO_AW:0]   level,
   output logic               overflow
);

   localparam int ACC_W = DATA_W + DECIM_LOG2;
   localparam int SHIFT = ACC_W - OUT_W;
   localparam int DEPTH = 2 ** FIFO_AW;

   logic [ACC_W-1:0]      acc;
   logic [DECIM_LOG2-1:0] cnt;
   logic [ACC_W:0]        sum;
   logic [ACC_W:0]        rnd_sum;
   logic [ACC_W:0]        r;
   logic [OUT_W-1:0]      result;

   logic [OUT_W-1:0]      mem [DEPTH];
   logic [FIFO_AW-1:0]    wr_ptr;
   logic [FIFO_AW-1:0]    rd_ptr;
   logic [FIFO_AW:0]      count;

   logic accept;
   logic last;
   logic push_req;
   logic pop;
   logic full;
   logic do_push;

   assign sum = {1'b0, acc} + (ACC_W + 1)'(data_in);

   // Round half-up before the shift; with no shift there is nothing to round.
   if (SHIFT > 0) begin : g_round
      localparam logic [ACC_W:0] RND = (ACC_W + 1)'(1) << (SHIFT - 1);
      assign rnd_sum = sum + RND;
   end else begin : g_noround
      assign rnd_sum = sum;
   end

   assign r      = rnd_sum >> SHIFT;
   assign result = (|r[ACC_W:OUT_W]) ? '1 : r[OUT_W-1:0];

   // Handshake: a word transfers on a rising edge when out_valid && out_ready; out_valid
   // depends only on registered FIFO count, never on out_ready.
   assign out_valid = (count != '0);
   assign level     = count;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   assign accept   = en & ~clr;
   assign last     = &cnt;
   assign push_req = accept & last;
   assign pop      = out_valid & out_ready & ~clr;
   assign full     = (count == (FIFO_AW + 1)'(DEPTH));
   assign do_push  = push_req & (~full | pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc      <= '0;
         cnt      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         acc      <= '0;
         cnt      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            if (last) begin
               acc <= '0;
               cnt <= '0;
            end else begin
               acc <= sum[ACC_W-1:0];
               cnt <= cnt + 1'b1;
            end
         end
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !pop)      count <= count + 1'b1;
         else if (pop && !do_push) count <= count - 1'b1;
         // A result that finds the FIFO full with no simultaneous pop is lost.
         if (push_req && full && !pop) overflow <= 1'b1;
      end
   end

   // Storage is not reset; out_data is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= result;
   end

endmodule

// File: tb/tb_iob_fir_decim.sv
// Directed bench for iob_fir_decim: hand-computed words checked through an expected-word
// queue on every handshake, plus explicit flag/level checks at the listed boundaries.
module tb_iob_fir_decim;

   localparam int DATA_W = 13;
   localparam int OUT_W  = 8;
   localparam int FIFO_AW = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               clr;
   logic               en;
   logic [DATA_W-1:0]  data_in;
   logic [OUT_W-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [FIFO_AW:0]   level;
   logic               overflow;

   logic [OUT_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   iob_fir_decim #(
      .DATA_W(DATA_W), .OUT_W(OUT_W), .DECIM_LOG2(2), .FIFO_AW(FIFO_AW)
   ) dut (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .data_in(data_in),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .overflow(overflow)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, score any handshake happening on this edge, then advance
   // to 1 time unit past the edge.
   task automatic step(input logic e, input logic [DATA_W-1:0] d, input logic c);
      logic [OUT_W-1:0] w;
      en = e; data_in = d; clr = c;
      #1;
      if (out_valid && out_ready && !c) begin
         if (exp_q.size() == 0) check("spurious_pop", {31'd0, out_valid}, 32'd0);
         else begin
            w = exp_q.pop_front();
            check("pop_data", {24'd0, out_data}, {24'd0, w});
         end
      end
      @(posedge clk); #1;
      en = 1'b0; clr = 1'b0;
   endtask

   task automatic window(input logic [DATA_W-1:0] d);
      for (int i = 0; i < 4; i++) step(1'b1, d, 1'b0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"},    {31'd0, out_valid}, 32'd0);
      check({tag, "_level"},    {29'd0, level},     32'd0);
      check({tag, "_overflow"}, {31'd0, overflow},  32'd0);
      check({tag, "_data"},     {24'd0, out_data},  32'd0);
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; en = 1'b0; data_in = '0; out_ready = 1'b0;
      #12;
      check_idle("reset");
      rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, '0, 1'b0);
         check_idle("idle");
      end

      // Rounding: (400+64)>>7 = 3, appears right after the 4th sample
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 13'd100, 1'b0);
      check("r100_not_yet", {31'd0, out_valid}, 32'd0);
      step(1'b1, 13'd100, 1'b0);
      check("r100_valid", {31'd0, out_valid}, 32'd1);
      check("r100_level", {29'd0, level}, 32'd1);
      check("r100_data", {24'd0, out_data}, 32'd3);
      exp_q.push_back(8'd3);
      step(1'b0, '0, 1'b0);
      check("r100_drained", {29'd0, level}, 32'd0);

      // (256+64)>>7 = 2
      window(13'd64);
      check("r64_data", {24'd0, out_data}, 32'd2);
      exp_q.push_back(8'd2);
      step(1'b0, '0, 1'b0);

      // Saturation: (32764+64)>>7 = 256 -> 255
      window(13'd8191);
      check("sat_data", {24'd0, out_data}, 32'd255);
      exp_q.push_back(8'd255);
      step(1'b0, '0, 1'b0);
      check("sat_drained", {31'd0, out_valid}, 32'd0);

      // Backpressure and overflow
      out_ready = 1'b0;
      for (int w = 1; w <= 5; w++) begin
         for (int i = 0; i < 3; i++) step(1'b1, 13'd100, 1'b0);
         check("bp_overflow_before", {31'd0, overflow}, 32'd0);
         step(1'b1, 13'd100, 1'b0);
         if (w <= 4) begin
            exp_q.push_back(8'd3);
            check("bp_level", {29'd0, level}, w);
         end
      end
      check("ovf_set", {31'd0, overflow}, 32'd1);
      check("ovf_level", {29'd0, level}, 32'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
      check("ovf_drain_level", {29'd0, level}, 32'd0);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      check("ovf_sb_empty", exp_q.size(), 32'd0);
      step(1'b0, '0, 1'b1);
      check("clr_ovf", {31'd0, overflow}, 32'd0);

      // Push and pop together while full; order 3,2,255,6 then 16
      out_ready = 1'b0;
      window(13'd100);  exp_q.push_back(8'd3);
      window(13'd64);   exp_q.push_back(8'd2);
      window(13'd8191); exp_q.push_back(8'd255);
      window(13'd200);  exp_q.push_back(8'd6);
      check("full_level", {29'd0, level}, 32'd4);
      for (int i = 0; i < 3; i++) step(1'b1, 13'd500, 1'b0);
      out_ready = 1'b1;
      exp_q.push_back(8'd16);  // (2000+64)>>7
      step(1'b1, 13'd500, 1'b0);
      check("pp_level", {29'd0, level}, 32'd4);
      check("pp_overflow", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
      check("pp_sb_empty", exp_q.size(), 32'd0);
      check("pp_level_end", {29'd0, level}, 32'd0);

      // Mid-window clear (with en asserted, ignored) and gated enable
      step(1'b1, 13'd500, 1'b0);
      step(1'b1, 13'd500, 1'b0);
      step(1'b1, 13'd1000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 13'd200, 1'b0);
         step(1'b0, 13'd4000, 1'b0);
      end
      check("gate_not_yet", {31'd0, out_valid}, 32'd0);
      step(1'b1, 13'd200, 1'b0);
      check("gate_data", {24'd0, out_data}, 32'd6);
      exp_q.push_back(8'd6);
      step(1'b0, '0, 1'b0);

      // Asynchronous reset mid-window with a queued word
      out_ready = 1'b0;
      window(13'd100);
      step(1'b1, 13'd100, 1'b0);
      step(1'b1, 13'd100, 1'b0);
      rst = 1'b0;
      #2;
      check_idle("async_rst");
      exp_q.delete();
      rst = 1'b1;
      window(13'd64);
      check("post_rst_data", {24'd0, out_data}, 32'd2);
      check("post_rst_level", {29'd0, level}, 32'd1);
      out_ready = 1'b1;
      exp_q.push_back(8'd2);
      step(1'b0, '0, 1'b0);
      check("final_sb_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
